// File: rtl/bank_spill_fill_pkg.sv
// Shared constants and FSM encoding for the register-bank spill/fill engine.
package bank_spill_fill_pkg;

  localparam int NUM_REGISTERS_PER_BANK_DEF = 32;
  localparam int NUM_REG_BANKS_DEF          = 4;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int BANK_W     = 6;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SP_READ  = 3'd1,
    SP_WAIT  = 3'd2,
    SP_MEM   = 3'd3,
    FL_MEM   = 3'd4,
    FL_WRITE = 3'd5,
    DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/bank_spill_fill.sv
// Copies one register bank to memory (spill) or from memory (fill), one word
// at a time, over a 1-cycle-latency register file and a req/ack memory port.
module bank_spill_fill
  import bank_spill_fill_pkg::*;
#(
  parameter int NUM_REGISTERS_PER_BANK = NUM_REGISTERS_PER_BANK_DEF,
  parameter int NUM_REG_BANKS          = NUM_REG_BANKS_DEF
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  dir_i,
  input  logic [BANK_W-1:0]     bank_i,
  input  logic [ADDR_W-1:0]     memBase_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [BANK_W-1:0]     rfBankSelect_o,
  output logic                  rfReadEnable_o,
  output logic [REG_ADDR_W-1:0] rfReadAddr_o,
  input  logic [DATA_W-1:0]     rfReadData_i,
  output logic                  rfWriteEnable_o,
  output logic [REG_ADDR_W-1:0] rfWriteAddr_o,
  output logic [DATA_W-1:0]     rfWriteData_o,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [ADDR_W-1:0]     memAddr_o,
  output logic [DATA_W-1:0]     memWData_o,
  input  logic                  memAck_i,
  input  logic [DATA_W-1:0]     memRData_i
);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic                    dir_q, dir_d;
  logic                    error_q, error_d;

  logic                    bank_ok;
  logic                    last;
  logic [ADDR_W-1:0]       mem_addr;

  assign bank_ok  = ({{(32-BANK_W){1'b0}}, bank_i} < 32'(NUM_REG_BANKS));
  assign last     = (index_q == REG_ADDR_W'(NUM_REGISTERS_PER_BANK - 1));
  // Plain 16-bit add: wraps past 0xFFFF back to 0x0000.
  assign mem_addr = base_q + {{(ADDR_W-REG_ADDR_W){1'b0}}, index_q};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      index_q <= '0;
      buf_q   <= '0;
      base_q  <= '0;
      bank_q  <= '0;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      buf_q   <= buf_d;
      base_q  <= base_d;
      bank_q  <= bank_d;
      dir_q   <= dir_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i && bank_ok) state_d = dir_i ? FL_MEM : SP_READ;
      SP_READ:  state_d = SP_WAIT;
      SP_WAIT:  state_d = SP_MEM;
      SP_MEM:   if (memAck_i) state_d = last ? DONE : SP_READ;
      FL_MEM:   if (memAck_i) state_d = FL_WRITE;
      FL_WRITE: state_d = last ? DONE : FL_MEM;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request latching, word index and data buffer.
  always_comb begin
    index_d = index_q;
    buf_d   = buf_q;
    base_d  = base_q;
    bank_d  = bank_q;
    dir_d   = dir_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (bank_ok) begin
            dir_d   = dir_i;
            bank_d  = bank_i;
            base_d  = memBase_i;
            index_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      SP_WAIT:  buf_d = rfReadData_i;
      SP_MEM:   if (memAck_i && !last) index_d = index_q + 1'b1;
      FL_MEM:   if (memAck_i) buf_d = memRData_i;
      FL_WRITE: if (!last) index_d = index_q + 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    busy_o          = 1'b0;
    done_o          = 1'b0;
    rfBankSelect_o  = '0;
    rfReadEnable_o  = 1'b0;
    rfReadAddr_o    = '0;
    rfWriteEnable_o = 1'b0;
    rfWriteAddr_o   = '0;
    rfWriteData_o   = '0;
    memReq_o        = 1'b0;
    memWe_o         = 1'b0;
    memAddr_o       = '0;
    memWData_o      = '0;
    if (state_q != IDLE) begin
      busy_o         = 1'b1;
      rfBankSelect_o = bank_q;
    end
    case (state_q)
      SP_READ: begin
        rfReadEnable_o = 1'b1;
        rfReadAddr_o   = index_q;
      end
      SP_MEM: begin
        memReq_o   = 1'b1;
        memWe_o    = ~dir_q;
        memAddr_o  = mem_addr;
        memWData_o = buf_q;
      end
      FL_MEM: begin
        memReq_o  = 1'b1;
        memAddr_o = mem_addr;
      end
      FL_WRITE: begin
        rfWriteEnable_o = 1'b1;
        rfWriteAddr_o   = index_q;
        rfWriteData_o   = buf_q;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign error_o = error_q;

endmodule
